// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller that handles external-RAM wait states,
// load-use stalls and branch flushes, with a sticky RAM-timeout flag and a stall-cycle counter.
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int TIMEOUT    = 16,
    parameter int DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic        branch_taken,
    input  logic        imem_ack,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic w_tmo, w_dfreeze, w_fwait, w_luse, w_br;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        // A wait that hits its last allowed cycle is released as though acknowledged.
        w_tmo     = (state_q != ST_RUN) && (wcnt_q == TMO_LAST);
        w_dfreeze = dmem_req && !dmem_ack && !((state_q == ST_DWAIT) && w_tmo);
        w_fwait   = !w_dfreeze && !imem_ack && !((state_q == ST_IWAIT) && w_tmo);
        w_luse    = !w_dfreeze && !w_fwait && stall_id;
        w_br      = !w_dfreeze && !w_fwait && !stall_id && branch_taken;

        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_dfreeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (w_fwait || w_luse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (w_br) begin
            ifid_flush = (DELAY_SLOT == 0);
        end

        state_d = ST_RUN;
        wcnt_d  = 8'd0;
        if (w_dfreeze) begin
            state_d = ST_DWAIT;
            wcnt_d  = (state_q == ST_DWAIT) ? wcnt_q + 8'd1 : 8'd0;
        end else if (state_q == ST_DWAIT) begin
            state_d = ST_RUN;
        end else if (w_fwait) begin
            state_d = ST_IWAIT;
            wcnt_d  = (state_q == ST_IWAIT) ? wcnt_q + 8'd1 : 8'd0;
        end

        err_d = err_q || (w_tmo &&
                (((state_q == ST_DWAIT) && dmem_req && !dmem_ack) ||
                 ((state_q == ST_IWAIT) && !imem_ack)));

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl, using a default instance and
// a TIMEOUT=4 / DELAY_SLOT=0 instance driven by the same inputs.
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic clk, rst;
    logic stall_id, branch_taken, imem_ack, dmem_req, dmem_ack;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, memwb_bubble, err;
    logic [15:0] stall_cnt;
    logic pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_flush2, idex_bubble2, memwb_bubble2, err2;
    logic [15:0] stall_cnt2;

    logic [7:0] o1, o2;
    assign o1 = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, memwb_bubble};
    assign o2 = {pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_flush2, idex_bubble2, memwb_bubble2};

    localparam logic [7:0] RUNO   = 8'b11111_000;
    localparam logic [7:0] FREEZE = 8'b00000_001;
    localparam logic [7:0] STALL  = 8'b00111_010;
    localparam logic [7:0] FLUSH  = 8'b11111_100;
    localparam logic [7:0] ALL0   = 8'b00000_000;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .stall_id(stall_id), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble), .err(err), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .DELAY_SLOT(0)) dut2 (
        .clk(clk), .rst(rst), .stall_id(stall_id), .branch_taken(branch_taken),
        .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2),
        .memwb_en(memwb_en2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
        .memwb_bubble(memwb_bubble2), .err(err2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_id = 0; branch_taken = 0; imem_ack = 1; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (o1 !== ALL0) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", o1, ALL0); end
        n_vec++; if (o2 !== ALL0) begin n_err++; $display("FAIL reset_outs2 got=%b exp=%b", o2, ALL0); end
        n_vec++; if (stall_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL reset_regs cnt=%0d err=%b exp 0/0", stall_cnt, err); end
        do_reset();
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL reset_release got=%b exp=%b", o1, RUNO); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dmem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 5; i++) cyc();
        n_vec++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL midwait_pre_cnt got=%0d exp=5", stall_cnt); end
        #2 rst = 1;
        #1;
        n_vec++; if (o1 !== ALL0) begin n_err++; $display("FAIL midwait_rst_outs got=%b exp=%b", o1, ALL0); end
        n_vec++; if (stall_cnt !== 16'd0 || err !== 1'b0) begin n_err++; $display("FAIL midwait_rst_regs cnt=%0d err=%b exp 0/0", stall_cnt, err); end
        n_vec++; if (dut.state_q !== 2'd0) begin n_err++; $display("FAIL midwait_rst_state got=%0d exp=0", dut.state_q); end
        cyc();
        n_vec++; if (o1 !== ALL0) begin n_err++; $display("FAIL midwait_rst_hold got=%b exp=%b", o1, ALL0); end
        rst = 0; dmem_req = 0; #1;
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL midwait_release got=%b exp=%b", o1, RUNO); end
    endtask

    task automatic test_load_use();
        do_reset();
        stall_id = 1; #1;
        n_vec++; if (o1 !== STALL) begin n_err++; $display("FAIL loaduse_outs got=%b exp=%b", o1, STALL); end
        cyc();
        stall_id = 0; #1;
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL loaduse_after got=%b exp=%b", o1, RUNO); end
        n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL loaduse_cnt got=%0d exp=1", stall_cnt); end
        cyc();
        n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL loaduse_cnt_hold got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_data_wait();
        do_reset();
        dmem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (o1 !== FREEZE) begin n_err++; $display("FAIL dwait_freeze[%0d] got=%b exp=%b", i, o1, FREEZE); end
            cyc();
        end
        dmem_ack = 1; #1;
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL dwait_ack got=%b exp=%b", o1, RUNO); end
        cyc();
        dmem_req = 0; dmem_ack = 1; #1;
        n_vec++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL dwait_cnt got=%0d exp=3", stall_cnt); end
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL dwait_stray_ack got=%b exp=%b", o1, RUNO); end
        cyc();
        n_vec++; if (err !== 1'b0 || err2 !== 1'b0) begin n_err++; $display("FAIL dwait_no_err got=%b/%b exp=0/0", err, err2); end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1; dmem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (o2 !== FREEZE || err2 !== 1'b0) begin n_err++; $display("FAIL tmo_freeze[%0d] got=%b err=%b exp=%b err=0", i, o2, err2, FREEZE); end
            cyc();
        end
        n_vec++; if (o2 !== RUNO) begin n_err++; $display("FAIL tmo_release got=%b exp=%b", o2, RUNO); end
        n_vec++; if (o1 !== FREEZE) begin n_err++; $display("FAIL tmo_long_still_frozen got=%b exp=%b", o1, FREEZE); end
        cyc();
        n_vec++; if (err2 !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL tmo_err got=%b/%b exp=1/0", err2, err); end
        n_vec++; if (o2 !== FREEZE) begin n_err++; $display("FAIL tmo_refreeze got=%b exp=%b", o2, FREEZE); end
        dmem_ack = 1; cyc();
        dmem_req = 0; dmem_ack = 0; cyc(); cyc();
        n_vec++; if (err2 !== 1'b1 || o2 !== RUNO) begin n_err++; $display("FAIL tmo_sticky err=%b outs=%b exp=1/%b", err2, o2, RUNO); end
    endtask

    task automatic test_iwait();
        do_reset();
        imem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (o1 !== STALL || o2 !== STALL) begin n_err++; $display("FAIL iwait[%0d] got=%b/%b exp=%b", i, o1, o2, STALL); end
            cyc();
        end
        n_vec++; if (o2 !== RUNO || o1 !== STALL) begin n_err++; $display("FAIL iwait_tmo got=%b/%b exp=%b/%b", o2, o1, RUNO, STALL); end
        cyc();
        n_vec++; if (err2 !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL iwait_err got=%b/%b exp=1/0", err2, err); end
        imem_ack = 1; #1;
        n_vec++; if (o1 !== RUNO) begin n_err++; $display("FAIL iwait_ack got=%b exp=%b", o1, RUNO); end
        cyc();
        n_vec++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL iwait_cnt got=%0d exp=5", stall_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        stall_id = 1; branch_taken = 1; imem_ack = 0; dmem_req = 1; dmem_ack = 0; #1;
        n_vec++; if (o1 !== FREEZE || o2 !== FREEZE) begin n_err++; $display("FAIL prio_freeze got=%b/%b exp=%b", o1, o2, FREEZE); end
        cyc();
        dmem_ack = 1; #1;
        n_vec++; if (o1 !== STALL || o2 !== STALL) begin n_err++; $display("FAIL prio_fetch got=%b/%b exp=%b", o1, o2, STALL); end
        cyc();
        dmem_req = 0; dmem_ack = 0; imem_ack = 1; #1;
        n_vec++; if (o2 !== STALL) begin n_err++; $display("FAIL prio_loaduse got=%b exp=%b", o2, STALL); end
        stall_id = 0; #1;
        n_vec++; if (o1 !== RUNO || o2 !== FLUSH) begin n_err++; $display("FAIL prio_branch got=%b/%b exp=%b/%b", o1, o2, RUNO, FLUSH); end
        cyc();
        branch_taken = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        stall_id = 1;
        for (int i = 0; i < 70000; i++) cyc();
        n_vec++; if (stall_cnt !== 16'hFFFF || stall_cnt2 !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt got=%h/%h exp=ffff", stall_cnt, stall_cnt2); end
        cyc();
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        stall_id = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_reset_mid_wait();
        test_load_use();
        test_data_wait();
        test_timeout();
        test_iwait();
        test_priority();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
